// File: rtl/block_transfer_sequencer.sv
// Load/store-multiple sequencer: walks a 16-bit register list lowest-first, issuing one
// memory transfer per set bit at ascending word addresses, then reports base writeback.
module block_transfer_sequencer #(
    parameter int ADDR_W     = 32,
    parameter int WORD_BYTES = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [15:0]       reg_list,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              load,
    input  logic              pre_index,
    input  logic              up,
    input  logic              writeback,
    input  logic              mem_ack,
    output logic              busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        reg_address,
    output logic              rf_we,
    output logic              rf_re,
    output logic [4:0]        xfer_count,
    output logic              done,
    output logic              wb_en,
    output logic [ADDR_W-1:0] wb_value
);

    typedef enum logic [1:0] {IDLE, SETUP, XFER, FINISH} state_t;

    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(WORD_BYTES);

    state_t            state, state_next;
    logic [15:0]       list_r;
    logic [ADDR_W-1:0] base_r;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] wb_r;
    logic              load_r, pre_r, up_r, wbk_r;
    logic [4:0]        n_r;
    logic [4:0]        count_r;
    logic [3:0]        reg_r;

    logic [15:0]       list_next;
    logic [4:0]        n_setup;
    logic [ADDR_W-1:0] span;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] wb_calc;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < 16; i++) c = c + 5'(v[i]);
        return c;
    endfunction

    function automatic logic [3:0] lowest_set(input logic [15:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = 15; i >= 0; i--) if (v[i]) idx = 4'(i);
        return idx;
    endfunction

    // Clearing the lowest set bit yields the list remaining after the current transfer.
    assign list_next = list_r & (list_r - 16'd1);

    always_comb begin
        n_setup = popcount16(list_r);
        span    = ADDR_W'(n_setup) * STRIDE;
        unique case ({pre_r, up_r})
            2'b01:   start_addr = base_r;
            2'b11:   start_addr = base_r + STRIDE;
            2'b00:   start_addr = base_r - span + STRIDE;
            default: start_addr = base_r - span;
        endcase
        wb_calc = up_r ? (base_r + span) : (base_r - span);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        done       = 1'b0;
        wb_en      = 1'b0;
        unique case (state)
            IDLE:   if (start) state_next = SETUP;
            SETUP:  state_next = (n_setup == 5'd0) ? FINISH : XFER;
            XFER: begin
                mem_req = 1'b1;
                if (mem_ack && (list_next == 16'd0)) state_next = FINISH;
            end
            FINISH: begin
                done       = 1'b1;
                wb_en      = wbk_r & (n_r != 5'd0);
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            list_r  <= '0;
            base_r  <= '0;
            addr_r  <= '0;
            wb_r    <= '0;
            load_r  <= 1'b0;
            pre_r   <= 1'b0;
            up_r    <= 1'b0;
            wbk_r   <= 1'b0;
            n_r     <= '0;
            count_r <= '0;
            reg_r   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        list_r  <= reg_list;
                        base_r  <= base_addr;
                        load_r  <= load;
                        pre_r   <= pre_index;
                        up_r    <= up;
                        wbk_r   <= writeback;
                        count_r <= '0;
                    end
                end
                SETUP: begin
                    n_r    <= n_setup;
                    addr_r <= start_addr;
                    wb_r   <= wb_calc;
                    reg_r  <= lowest_set(list_r);
                end
                XFER: begin
                    if (mem_ack) begin
                        list_r  <= list_next;
                        addr_r  <= addr_r + STRIDE;
                        count_r <= count_r + 5'd1;
                        reg_r   <= lowest_set(list_next);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (state != IDLE);
    assign mem_we      = mem_req & ~load_r;
    assign rf_re       = mem_req & ~load_r;
    assign rf_we       = mem_req & load_r & mem_ack;
    assign mem_addr    = addr_r;
    assign reg_address = reg_r;
    assign xfer_count  = count_r;
    assign wb_value    = wb_r;

endmodule

// File: tb/tb_block_transfer_sequencer.sv
// Directed bench for block_transfer_sequencer: one task per scenario, inline comparisons
// against hand-computed addresses, register indices, counts and writeback values.
module tb_block_transfer_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [15:0] reg_list;
    logic [31:0] base_addr;
    logic        load, pre_index, up, writeback, mem_ack;
    logic        busy, mem_req, mem_we, rf_we, rf_re, done, wb_en;
    logic [31:0] mem_addr, wb_value;
    logic [3:0]  reg_address;
    logic [4:0]  xfer_count;
    logic [79:0] outs;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign outs = {busy, mem_req, mem_we, rf_we, rf_re, done, wb_en,
                   mem_addr, wb_value, reg_address, xfer_count};

    block_transfer_sequencer #(.ADDR_W(32), .WORD_BYTES(4)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .reg_list(reg_list),
        .base_addr(base_addr), .load(load), .pre_index(pre_index), .up(up),
        .writeback(writeback), .mem_ack(mem_ack), .busy(busy), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .reg_address(reg_address),
        .rf_we(rf_we), .rf_re(rf_re), .xfer_count(xfer_count), .done(done),
        .wb_en(wb_en), .wb_value(wb_value)
    );

    // Start pulse then scramble all start-sampled inputs; returns in the SETUP cycle.
    task automatic do_start(input logic [15:0] l, input logic [31:0] b,
                            input logic ld, input logic p, input logic u, input logic w);
        @(negedge clk);
        start = 1'b1; reg_list = l; base_addr = b;
        load = ld; pre_index = p; up = u; writeback = w;
        @(negedge clk);
        start = 1'b0; reg_list = 16'hA5A5; base_addr = 32'hDEAD_BEEF;
        load = ~ld; pre_index = ~p; up = ~u; writeback = ~w;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; start = 1'b0; reg_list = '0; base_addr = '0;
        load = 1'b0; pre_index = 1'b0; up = 1'b0; writeback = 1'b0; mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        #1; checks++;
        if (outs !== 80'd0) begin
            errors++; $display("FAIL reset_outputs: got %h expected 0", outs);
        end
        @(negedge clk); reset_n = 1'b1;
        @(negedge clk); #1; checks++;
        if (outs !== 80'd0) begin
            errors++; $display("FAIL idle_after_reset: got %h expected 0", outs);
        end
    endtask

    task automatic test_stm_ia;
        logic [31:0] ea [3] = '{32'h100, 32'h104, 32'h108};
        logic [3:0]  er [3] = '{4'd0, 4'd1, 4'd4};
        mem_ack = 1'b1;
        do_start(16'h0013, 32'h100, 1'b0, 1'b0, 1'b1, 1'b1);
        #1; checks++;
        if ({busy, mem_req, done} !== 3'b100) begin
            errors++; $display("FAIL stm_setup: got %b expected 100", {busy, mem_req, done});
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1; checks++;
            if ({mem_req, mem_we, rf_re, rf_we, mem_addr, reg_address, xfer_count}
                !== {4'b1110, ea[k], er[k], 5'(k)}) begin
                errors++;
                $display("FAIL stm_xfer%0d: got req/we/re/rfwe=%b%b%b%b addr=%h reg=%0d cnt=%0d expected 1110 addr=%h reg=%0d cnt=%0d",
                         k, mem_req, mem_we, rf_re, rf_we, mem_addr, reg_address, xfer_count, ea[k], er[k], k);
            end
        end
        @(negedge clk); #1; checks++;
        if ({done, wb_en, mem_req, wb_value, xfer_count} !== {3'b110, 32'h10C, 5'd3}) begin
            errors++;
            $display("FAIL stm_finish: got done=%b wb_en=%b req=%b wb=%h cnt=%0d expected 1 1 0 10c 3",
                     done, wb_en, mem_req, wb_value, xfer_count);
        end
        @(negedge clk); #1; checks++;
        if ({busy, done, wb_en} !== 3'b000) begin
            errors++; $display("FAIL stm_idle: got %b expected 000", {busy, done, wb_en});
        end
    endtask

    task automatic test_ldm_db;
        logic [31:0] ea [2] = '{32'h1F8, 32'h1FC};
        logic [3:0]  er [2] = '{4'd0, 4'd15};
        mem_ack = 1'b1;
        do_start(16'h8001, 32'h200, 1'b1, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); #1; checks++;
            if ({mem_req, mem_we, rf_re, rf_we, mem_addr, reg_address}
                !== {4'b1001, ea[k], er[k]}) begin
                errors++;
                $display("FAIL ldm_xfer%0d: got req/we/re/rfwe=%b%b%b%b addr=%h reg=%0d expected 1001 addr=%h reg=%0d",
                         k, mem_req, mem_we, rf_re, rf_we, mem_addr, reg_address, ea[k], er[k]);
            end
        end
        @(negedge clk); #1; checks++;
        if ({done, wb_en, rf_we, wb_value} !== {3'b110, 32'h1F8}) begin
            errors++;
            $display("FAIL ldm_finish: got done=%b wb_en=%b rf_we=%b wb=%h expected 1 1 0 1f8",
                     done, wb_en, rf_we, wb_value);
        end
    endtask

    task automatic test_wait_states;
        logic [31:0] ea [2] = '{32'h4, 32'h8};
        logic [3:0]  er [2] = '{4'd1, 4'd2};
        mem_ack = 1'b0;
        do_start(16'h0006, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int t = 0; t < 2; t++) begin
            for (int w = 0; w < 3; w++) begin
                @(negedge clk); mem_ack = 1'b0; #1; checks++;
                if ({mem_req, rf_we, mem_addr, reg_address, xfer_count}
                    !== {2'b10, ea[t], er[t], 5'(t)}) begin
                    errors++;
                    $display("FAIL wait_hold%0d_%0d: got req=%b rfwe=%b addr=%h reg=%0d cnt=%0d expected 1 0 %h %0d %0d",
                             t, w, mem_req, rf_we, mem_addr, reg_address, xfer_count, ea[t], er[t], t);
                end
            end
            @(negedge clk); mem_ack = 1'b1; #1; checks++;
            if ({mem_req, rf_we, mem_addr, reg_address} !== {2'b11, ea[t], er[t]}) begin
                errors++;
                $display("FAIL wait_ack%0d: got req=%b rfwe=%b addr=%h reg=%0d expected 1 1 %h %0d",
                         t, mem_req, rf_we, mem_addr, reg_address, ea[t], er[t]);
            end
        end
        @(negedge clk); mem_ack = 1'b0; #1; checks++;
        if ({done, wb_en, mem_req, xfer_count} !== {3'b100, 5'd2}) begin
            errors++;
            $display("FAIL wait_finish: got done=%b wb_en=%b req=%b cnt=%0d expected 1 0 0 2",
                     done, wb_en, mem_req, xfer_count);
        end
    endtask

    task automatic test_empty;
        mem_ack = 1'b1;
        do_start(16'h0000, 32'h300, 1'b0, 1'b0, 1'b1, 1'b1);
        #1; checks++;
        if ({busy, mem_req, done} !== 3'b100) begin
            errors++; $display("FAIL empty_setup: got %b expected 100", {busy, mem_req, done});
        end
        @(negedge clk); #1; checks++;
        if ({done, wb_en, mem_req, xfer_count} !== {3'b100, 5'd0}) begin
            errors++;
            $display("FAIL empty_finish: got done=%b wb_en=%b req=%b cnt=%0d expected 1 0 0 0",
                     done, wb_en, mem_req, xfer_count);
        end
    endtask

    task automatic test_full;
        mem_ack = 1'b1;
        do_start(16'hFFFF, 32'h40, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk); #1; checks++;
            if ({mem_req, mem_addr, reg_address, xfer_count}
                !== {1'b1, 32'(4 + 4 * k), 4'(k), 5'(k)}) begin
                errors++;
                $display("FAIL full_xfer%0d: got req=%b addr=%h reg=%0d cnt=%0d expected 1 %h %0d %0d",
                         k, mem_req, mem_addr, reg_address, xfer_count, 32'(4 + 4 * k), k, k);
            end
        end
        @(negedge clk); #1; checks++;
        if ({done, wb_en, wb_value, xfer_count} !== {2'b11, 32'h0, 5'd16}) begin
            errors++;
            $display("FAIL full_finish: got done=%b wb_en=%b wb=%h cnt=%0d expected 1 1 0 16",
                     done, wb_en, wb_value, xfer_count);
        end
    endtask

    task automatic test_abort;
        mem_ack = 1'b1;
        do_start(16'h00FF, 32'h500, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        @(negedge clk); #1; checks++;
        if ({mem_req, mem_addr, reg_address} !== {1'b1, 32'h504, 4'd1}) begin
            errors++;
            $display("FAIL abort_second: got req=%b addr=%h reg=%0d expected 1 504 1",
                     mem_req, mem_addr, reg_address);
        end
        reset_n = 1'b0;
        #1; checks++;
        if (outs !== 80'd0) begin
            errors++; $display("FAIL abort_async: got %h expected 0", outs);
        end
        @(negedge clk); reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1; checks++;
            if ({busy, mem_req, done, wb_en} !== 4'b0000) begin
                errors++;
                $display("FAIL abort_quiet%0d: got busy/req/done/wb_en=%b expected 0000",
                         c, {busy, mem_req, done, wb_en});
            end
        end
    endtask

    task automatic test_back_to_back;
        mem_ack = 1'b1;
        do_start(16'h0005, 32'h1000, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk); start = 1'b1; reg_list = 16'hFFFF; base_addr = 32'h0; #1; checks++;
        if ({mem_req, mem_addr, reg_address} !== {1'b1, 32'h1000, 4'd0}) begin
            errors++;
            $display("FAIL b2b_xfer0: got req=%b addr=%h reg=%0d expected 1 1000 0",
                     mem_req, mem_addr, reg_address);
        end
        @(negedge clk); #1; checks++;
        if ({mem_req, mem_addr, reg_address} !== {1'b1, 32'h1004, 4'd2}) begin
            errors++;
            $display("FAIL b2b_xfer1: got req=%b addr=%h reg=%0d expected 1 1004 2",
                     mem_req, mem_addr, reg_address);
        end
        @(negedge clk); start = 1'b0; #1; checks++;
        if ({done, wb_en, wb_value, xfer_count} !== {2'b11, 32'h1008, 5'd2}) begin
            errors++;
            $display("FAIL b2b_finish: got done=%b wb_en=%b wb=%h cnt=%0d expected 1 1 1008 2",
                     done, wb_en, wb_value, xfer_count);
        end
        @(negedge clk); #1; checks++;
        if ({busy, mem_req} !== 2'b00) begin
            errors++; $display("FAIL b2b_idle: got busy/req=%b expected 00", {busy, mem_req});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stm_ia();
        test_ldm_db();
        test_wait_states();
        test_empty();
        test_full();
        test_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/block_transfer_sequencer.md
Name: block_transfer_sequencer

Overview:
- Walks a 16-bit register list for load/store-multiple instructions.
- Issues one memory transfer per set bit, lowest register first, at ascending word addresses.
- Signals done and the base-register writeback value when the list is consumed.
- Sits between the control unit and the memory interface, and drives register-file address and enable strobes.

Parameters:
ADDR_W, 32, memory address and base-register width
WORD_BYTES, 4, address stride per transfer

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  begin sequence; sampled only in IDLE
reg_list  in  16  bit i set = transfer register Ri; captured on start
base_addr  in  ADDR_W  base register value; captured on start
load  in  1  1 = LDM (memory->regs), 0 = STM; captured on start
pre_index  in  1  P bit; captured on start
up  in  1  U bit; captured on start
writeback  in  1  W bit; captured on start
mem_ack  in  1  memory completes current transfer this cycle
busy  out  1  high from the cycle after start until IDLE is re-entered
mem_req  out  1  transfer request; held high until acked
mem_we  out  1  1 = memory write (STM); valid with mem_req
mem_addr  out  ADDR_W  current transfer word address
reg_address  out  4  register for current transfer
rf_we  out  1  register-file write strobe (LDM): load & mem_req & mem_ack
rf_re  out  1  register-file read strobe (STM): !load & mem_req
xfer_count  out  5  transfers completed in current sequence
done  out  1  one-cycle pulse at end of sequence
wb_en  out  1  one-cycle base writeback strobe, coincident with done
wb_value  out  ADDR_W  new base value, valid while wb_en

Behaviour:
Reset:
- On reset_n low, asynchronously go to IDLE.
- All outputs 0; working list and counters cleared.
- Reset mid-sequence aborts with no done or wb_en pulse.

States: IDLE, SETUP, XFER, FINISH.

IDLE:
- start=1 captures all start-sampled inputs and moves to SETUP.
- start=0 stays in IDLE.

SETUP (1 cycle):
- n = popcount(reg_list), range 0..16, width 5.
- Start address, modulo 2^ADDR_W:
  - IA (P=0,U=1): base
  - IB (P=1,U=1): base+4
  - DA (P=0,U=0): base-4n+4
  - DB (P=1,U=0): base-4n
- wb_value = U ? base+4n : base-4n.
- reg_address = index of lowest set bit.
- n=0 goes to FINISH; otherwise goes to XFER.

XFER:
- mem_req=1 while in this state; mem_we = !load.
- On mem_ack:
  - Clear the lowest set bit of the working list.
  - mem_addr += WORD_BYTES.
  - xfer_count += 1.
  - reg_address moves to the next lowest set bit, registered and valid next cycle.
- Ack of the last set bit goes to FINISH; mem_req drops the next cycle.
- No ack: hold all outputs stable, with unlimited wait states.

FINISH (1 cycle):
- done=1.
- wb_en = writeback & (n != 0).
- Return to IDLE.

Rules:
- start while busy is ignored.
- mem_ack outside XFER is ignored.
- The external reg_list may change after start without effect.
- Latency with zero-wait memory (ack in the same cycle as req): start to done = n+2 cycles, one transfer per cycle.
- Address wrap past 2^ADDR_W-1 wraps silently.
- Registers always transfer in ascending order at ascending addresses, regardless of U.

Test Plan:
- STM IA, W=1: list=0x0013, base=0x100, ack tied 1.
  - Required: transfers R0@0x100, R1@0x104, R4@0x108 on consecutive cycles, mem_we=1, rf_re=1.
  - Then done and wb_en pulse with wb_value=0x10C; start-to-done = 5 cycles.
- LDM DB, W=1: list=0x8001, base=0x200.
  - Required: R0@0x1F8, R15@0x1FC; rf_we pulses twice; wb_value=0x1F8.
- Wait states: LDM IB, list=0x0006, base=0, ack after 3 idle cycles per request.
  - Required: mem_addr=0x4 and reg_address=1 held stable 3 cycles, then 0x8 / R2.
  - Then done with xfer_count=2.
- Empty list: start with list=0x0000, W=1.
  - Required: no mem_req; done 2 cycles after start; wb_en=0.
- Full list: list=0xFFFF, DA, base=0x40.
  - Required: first addr 0x04, last addr 0x40 (R15); wb_value=0x00; xfer_count reaches 16.
- Abort and ignore: reset_n low during the 2nd transfer of list=0x00FF.
  - Required: immediate IDLE, no done or wb_en, all outputs 0.
  - A start pulse while busy in a later sequence does not disturb it.
